// File: rtl/char_display_sequencer.sv
// char_display_sequencer: buffers a message of 4-bit character codes and
// writes it to the four display positions with one-cycle load pulses.
// Ports: clk, reset (async, active-high); in_valid/in_ready/in_data beats;
// commit ends a message; busy, msg_len status; disp_data/disp_position/
// disp_load drive the display. Build option: SCROLL_EN enables scrolling
// of messages longer than four characters.
module char_display_sequencer #(
  parameter int          MSG_DEPTH    = 8,
  parameter logic [23:0] SCROLL_TICKS = 24'd10_000_000,
  parameter logic [3:0]  BLANK_CODE   = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic       commit,
  output logic       busy,
  output logic [3:0] msg_len,
  output logic [3:0] disp_data,
  output logic [1:0] disp_position,
  output logic       disp_load
);

  localparam int         IW    = $clog2(MSG_DEPTH);
  localparam logic [3:0] DEPTH = 4'(MSG_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    REFRESH,
    HOLD
  } state_t;

  state_t state, state_nx;

  logic [3:0] msg_buf [MSG_DEPTH];
  logic [3:0] count;
  logic [3:0] len;
  logic [3:0] eff_len;
  logic [2:0] offset;
  logic [3:0] slot;
  logic [1:0] pos;
  logic       accept;
  logic       start;
  logic       scroll;
  logic       scroll_due;
  logic [3:0] char_idx;
  logic [3:0] char_code;

  // Each position uses two slots: even slot loads, odd slot idles.
  // Slot 8 is the trailing busy cycle before HOLD.
  assign pos = slot[2:1];

`ifdef SCROLL_EN
  logic [23:0] tick;

  // Compared against TICKS-2: the refresh starts on the edge where
  // the counter would reach TICKS-1.
  assign scroll_due = (state == HOLD) && (len > 4'd4) &&
                      (tick == SCROLL_TICKS - 24'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick <= '0;
    end else if (state == HOLD && len > 4'd4) begin
      tick <= tick + 24'd1;
    end else begin
      tick <= '0;
    end
  end
`else
  assign scroll_due = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    eff_len  = count;
    scroll   = 1'b0;
    unique case (state)
      IDLE, FILL: in_ready = (count < DEPTH);
      HOLD:       in_ready = 1'b1;
      default:    in_ready = 1'b0;
    endcase
    accept = in_valid && in_ready;
    // count is 0 in HOLD, so a HOLD beat starts a one-char message,
    // while a bare commit in HOLD replays the stored message.
    if (accept) begin
      eff_len = count + 4'd1;
    end else if (state == HOLD) begin
      eff_len = len;
    end
    start = commit && (state != REFRESH) && (eff_len != 4'd0);
    if (start) begin
      state_nx = REFRESH;
    end else if (accept) begin
      state_nx = FILL;
    end else if (state == REFRESH && slot == 4'd8) begin
      state_nx = HOLD;
    end else if (scroll_due) begin
      state_nx = REFRESH;
      scroll   = 1'b1;
    end
  end

  // offset < len and pos <= 3, so one subtraction wraps the window.
  always_comb begin
    char_idx = {1'b0, offset} + {2'b00, pos};
    if (char_idx >= len) begin
      char_idx = char_idx - len;
    end
    if (len > 4'd4) begin
      char_code = msg_buf[char_idx[IW-1:0]];
    end else if ({2'b00, pos} < len) begin
      char_code = msg_buf[IW'(pos)];
    end else begin
      char_code = BLANK_CODE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      msg_buf[count[IW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count         <= '0;
      len           <= '0;
      offset        <= '0;
      slot          <= '0;
      busy          <= 1'b0;
      msg_len       <= '0;
      disp_data     <= '0;
      disp_position <= '0;
      disp_load     <= 1'b0;
    end else begin
      if (start) begin
        count <= '0;
      end else if (accept) begin
        count <= count + 4'd1;
      end

      if (start) begin
        len     <= eff_len;
        msg_len <= eff_len;
        offset  <= '0;
        slot    <= '0;
      end else if (scroll) begin
        offset <= ({1'b0, offset} + 4'd1 == len) ? 3'd0 : offset + 3'd1;
        slot   <= '0;
      end else if (state == REFRESH) begin
        if (slot == 4'd8) begin
          busy      <= 1'b0;
          disp_load <= 1'b0;
        end else begin
          busy      <= 1'b1;
          slot      <= slot + 4'd1;
          disp_load <= ~slot[0];
          if (!slot[0]) begin
            disp_position <= pos;
            disp_data     <= char_code;
          end
        end
      end
    end
  end

endmodule

// File: doc/char_display_sequencer.md
# char_display_sequencer

Message sequencer sitting in front of the character multiplexed display. It accepts a message of up to MSG_DEPTH 4-bit character codes over a valid/ready stream. On commit it writes the four display positions with load pulses on the display's data/position/load port. Messages longer than four characters are optionally scrolled one character every SCROLL_TICKS cycles.

## Interface

Parameters:
- MSG_DEPTH, 8: message buffer entries (power of two, 5..8).
- SCROLL_TICKS, 24'd10_000_000: cycles between scroll steps (≥ 9).
- BLANK_CODE, 4'hF: code written to unused positions.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  character beat valid.
- in_ready  out  1  sequencer can accept a beat.
- in_data  in  4  character code.
- commit  in  1  single-cycle strobe that ends the message and starts display.
- busy  out  1  refresh sequence in progress.
- msg_len  out  4  committed message length, 0..MSG_DEPTH.
- disp_data  out  4  character code to display.
- disp_position  out  2  target position, 0..3.
- disp_load  out  1  one-cycle write strobe to display.

## Operation

- FSM states: IDLE, FILL, REFRESH, HOLD. Registers: buf[MSG_DEPTH], count, len, offset (3 bits), pos (2 bits), phase, tick counter.
- Reset values: state IDLE, count 0, len 0, offset 0. All registered outputs are 0: disp_data, disp_position, disp_load, busy, msg_len.
- in_ready is combinational: 1 in HOLD; 1 in IDLE/FILL when count < MSG_DEPTH; 0 in REFRESH.
- Beat accepted when in_valid && in_ready.
  - IDLE/FILL: buf[count] <= in_data, count++, state FILL.
  - HOLD: aborts scrolling. buf[0] <= in_data, count <= 1, state FILL. Display keeps its last contents.
- commit in IDLE/FILL/HOLD:
  - Effective length is count, or count+1 if a beat is accepted in the same cycle.
  - If the effective length is 0, commit is ignored.
  - Otherwise len <= effective length, msg_len <= len, offset <= 0, pos <= 0, state REFRESH.
  - The same-cycle beat is stored before commit takes effect.
- commit in REFRESH is ignored.
- REFRESH writes positions 0..3 in order, two cycles each:
  - Cycle 1: disp_load=1, disp_position=pos, disp_data=char(pos).
  - Cycle 2: disp_load=0.
  - After pos 3, state HOLD.
- char(p) rule:
  - len ≤ 4: buf[p] if p < len, else BLANK_CODE.
  - len > 4: buf[(offset+p) mod len], with the sum computed in 4 bits and len subtracted once if ≥ len.
- HOLD: display static; see Configuration for scrolling.
- count resets to 0 on commit. A commit from HOLD without a beat re-displays the existing buffer from offset 0.

## Timing

- commit sampled at edge N: disp_load high in cycles N+1, N+3, N+5, N+7 for positions 0,1,2,3.
- busy is high N+1..N+8. HOLD is entered at N+9.
- disp_data and disp_position are stable for both cycles of each position slot.
- Scroll step: tick counter clears on HOLD entry. REFRESH begins when the count reaches SCROLL_TICKS−1, so the first load comes SCROLL_TICKS cycles after HOLD entry.
- On the scroll step, offset <= (offset+1 == len) ? 0 : offset+1.
- Reset asserted mid-REFRESH: outputs return to 0 asynchronously and the partial update is abandoned.

## Configuration

- SCROLL_EN defined:
  - In HOLD with len > 4, the tick counter runs and advances the window as above.
  - len ≤ 4 never scrolls.
- SCROLL_EN undefined:
  - No tick counter is synthesized; offset stays 0 and HOLD is terminal until a beat or commit.
  - Messages longer than 4 show buf[0..3] only.

## Test plan

- Reset, push 3, 5, 7 then commit → loads (pos,data) = (0,3),(1,5),(2,7),(3,F) at N+1/3/5/7; msg_len=3; busy high 8 cycles.
- Push 8 beats → in_ready drops to 0 after the 8th. A 9th in_valid is not accepted; commit gives msg_len=8.
- SCROLL_EN, SCROLL_TICKS=16, message 0..5:
  - Initial window 0,1,2,3.
  - After 16 HOLD cycles: 1,2,3,4.
  - At offset 5: 5,0,1,2.
  - Then wraps to offset 0.
- Beat and commit in the same cycle with count=2 → msg_len=3, third char displayed at pos 2.
- commit during REFRESH → ignored. Beat in HOLD → state FILL, count=1, no disp_load. commit with count 0 → no activity.
- Assert reset at REFRESH cycle 4 → all outputs 0 immediately, in_ready=1 after release, no further loads.
